// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package seg_scan_driver_pkg;

    localparam int unsigned NUM_DIG = 6;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [2:0] DIG_H10 = 3'd0;
    localparam logic [2:0] DIG_H1  = 3'd1;
    localparam logic [2:0] DIG_M10 = 3'd2;
    localparam logic [2:0] DIG_M1  = 3'd3;
    localparam logic [2:0] DIG_S10 = 3'd4;
    localparam logic [2:0] DIG_S1  = 3'd5;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-high 7-segment pattern; codes above 9 decode to blank.
module bcd_to_seg7
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed 7-segment driver: per-frame digit snapshot, one digit per scan slot,
// registered segment/dp/common outputs with configurable polarity.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int unsigned SCAN_DIV    = 50000,
    parameter bit          SEG_ACT_LOW = 1'b0,
    parameter bit          COM_ACT_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hour_10,
    input  logic [3:0] hour1,
    input  logic [3:0] min_10,
    input  logic [3:0] min1,
    input  logic [3:0] sec_10,
    input  logic [3:0] sec1,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] com,
    output logic       frame_done
);

    localparam int unsigned      CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [6:0]       SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic             DP_OFF  = SEG_ACT_LOW;
    localparam logic [5:0]       COM_OFF = COM_ACT_LOW ? 6'h3F : 6'h00;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [3:0]       snap_q [NUM_DIG];
    logic [3:0]       digits_in [NUM_DIG];
    logic             upd_q;
    logic             frame_done_q;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [5:0]       com_q, com_d;

    logic             tick;
    logic             wrap;
    logic [3:0]       digit;
    logic [6:0]       pattern;
    logic [6:0]       seg_pat;
    logic             colon;

    always_comb begin
        digits_in[DIG_H10] = hour_10;
        digits_in[DIG_H1]  = hour1;
        digits_in[DIG_M10] = min_10;
        digits_in[DIG_M1]  = min1;
        digits_in[DIG_S10] = sec_10;
        digits_in[DIG_S1]  = sec1;
    end

    // Slot sequencing; idx starts at the last slot so the first tick opens a frame.
    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d = idx_q;
        wrap  = 1'b0;
        if (idx_q > DIG_S1) begin
            idx_d = DIG_S1;
        end else if (tick) begin
            if (idx_q == DIG_S1) begin
                idx_d = DIG_H10;
                wrap  = 1'b1;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
    end

    always_comb begin
        digit = 4'hF;
        case (idx_q)
            DIG_H10: digit = snap_q[DIG_H10];
            DIG_H1:  digit = snap_q[DIG_H1];
            DIG_M10: digit = snap_q[DIG_M10];
            DIG_M1:  digit = snap_q[DIG_M1];
            DIG_S10: digit = snap_q[DIG_S10];
            DIG_S1:  digit = snap_q[DIG_S1];
            default: digit = 4'hF;
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd (digit),
        .seg (pattern)
    );

    // Colon sits after hours and minutes and blinks on even seconds.
    always_comb begin
        seg_pat = pattern;
        if (idx_q == DIG_H10 && blank_lz && snap_q[DIG_H10] == 4'd0) begin
            seg_pat = SEG_BLANK;
        end
        colon = ((idx_q == DIG_H1) || (idx_q == DIG_M1)) && !snap_q[DIG_S1][0];
        seg_d = SEG_ACT_LOW ? ~seg_pat : seg_pat;
        dp_d  = SEG_ACT_LOW ? ~colon : colon;
        com_d = COM_ACT_LOW ? ~(6'b000001 << idx_q) : (6'b000001 << idx_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q        <= '0;
            idx_q        <= DIG_S1;
            upd_q        <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            com_q        <= COM_OFF;
            for (int i = 0; i < NUM_DIG; i++) begin
                snap_q[i] <= 4'd0;
            end
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            upd_q        <= tick;
            frame_done_q <= wrap;
            if (wrap) begin
                for (int i = 0; i < NUM_DIG; i++) begin
                    snap_q[i] <= digits_in[i];
                end
            end
            // Outputs follow one cycle after the tick so they see the updated idx/snapshot.
            if (upd_q) begin
                seg_q <= seg_d;
                dp_q  <= dp_d;
                com_q <= com_d;
            end
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign com        = com_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver with SCAN_DIV=4, active-high segments,
// active-low commons.
module tb_seg_scan_driver;

    logic       clk;
    logic       rst;
    logic [3:0] hour_10, hour1, min_10, min1, sec_10, sec1;
    logic       blank_lz;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] com;
    logic       frame_done;

    int errors = 0;
    int checks = 0;

    seg_scan_driver #(
        .SCAN_DIV    (4),
        .SEG_ACT_LOW (1'b0),
        .COM_ACT_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hour_10    (hour_10),
        .hour1      (hour1),
        .min_10     (min_10),
        .min1       (min1),
        .sec_10     (sec_10),
        .sec1       (sec1),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dp         (dp),
        .com        (com),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // At most one common may ever be active (active-low).
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            checks++;
            if ($countones(~com) > 1) begin
                errors++;
                $display("FAIL onehot_com: com=%b has more than one active common", com);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic set_digits(input logic [3:0] h10, input logic [3:0] h1, input logic [3:0] m10,
                              input logic [3:0] m1, input logic [3:0] s10, input logic [3:0] s1);
        hour_10 = h10;
        hour1   = h1;
        min_10  = m10;
        min1    = m1;
        sec_10  = s10;
        sec1    = s1;
    endtask

    // Returns at the negedge where frame_done is seen high; a missing pulse counts as a failure.
    task automatic sync_frame(input string name);
        bit found = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s_sync: frame_done not seen within 60 cycles", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        blank_lz = 1'b0;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        repeat (2) @(negedge clk);
        checks++;
        if (seg !== 7'h00 || dp !== 1'b0 || com !== 6'h3F || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: seg=%h dp=%b com=%b fd=%b want 00 0 111111 0",
                     seg, dp, com, frame_done);
        end
        rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (frame_done !== (k == 4) || com !== 6'h3F || seg !== 7'h00) begin
                errors++;
                $display("FAIL first_frame_cycle%0d: fd=%b com=%b seg=%h want fd=%b com=111111 seg=00",
                         k, frame_done, com, seg, (k == 4));
            end
        end
    endtask

    task automatic test_first_frame();
        logic [6:0] exp_seg [6] = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D};
        logic       exp_dp  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (seg !== exp_seg[i] || dp !== exp_dp[i] || com !== ~(6'b000001 << i)
                || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL scan_slot%0d: seg=%h dp=%b com=%b fd=%b want %h %b %b 0", i, seg,
                         dp, com, frame_done, exp_seg[i], exp_dp[i], ~(6'b000001 << i));
            end
            repeat (3) @(negedge clk);
            checks++;
            if (seg !== exp_seg[i] || com !== ~(6'b000001 << i)) begin
                errors++;
                $display("FAIL hold_slot%0d: seg=%h com=%b want %h %b", i, seg, com, exp_seg[i],
                         ~(6'b000001 << i));
            end
        end
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL frame_period: fd=%b want 1 after 24 cycles", frame_done);
        end
    endtask

    task automatic test_mid_frame_change();
        sync_frame("midframe");
        repeat (10) @(negedge clk);
        min1 = 4'd9;
        repeat (3) @(negedge clk);
        checks++;
        if (seg !== 7'h66 || com !== 6'b110111) begin
            errors++;
            $display("FAIL midframe_old: seg=%h com=%b want 66 110111", seg, com);
        end
        sync_frame("midframe_next");
        repeat (13) @(negedge clk);
        checks++;
        if (seg !== 7'h6F || com !== 6'b110111) begin
            errors++;
            $display("FAIL midframe_new: seg=%h com=%b want 6f 110111", seg, com);
        end
    endtask

    task automatic test_blanking();
        set_digits(4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        blank_lz = 1'b1;
        sync_frame("blank_on");
        @(negedge clk);
        checks++;
        if (seg !== 7'h00 || com !== 6'b111110) begin
            errors++;
            $display("FAIL blank_lz_on: seg=%h com=%b want 00 111110", seg, com);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (seg !== 7'h5B || com !== 6'b111101) begin
            errors++;
            $display("FAIL blank_lz_slot1: seg=%h com=%b want 5b 111101", seg, com);
        end
        blank_lz = 1'b0;
        sync_frame("blank_off");
        @(negedge clk);
        checks++;
        if (seg !== 7'h3F || com !== 6'b111110) begin
            errors++;
            $display("FAIL blank_lz_off: seg=%h com=%b want 3f 111110", seg, com);
        end
    endtask

    task automatic test_colon();
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7);
        sync_frame("colon_odd");
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (dp !== 1'b0 || com !== ~(6'b000001 << i)) begin
                errors++;
                $display("FAIL colon_odd_slot%0d: dp=%b com=%b want 0 %b", i, dp, com,
                         ~(6'b000001 << i));
            end
            if (i == 5) begin
                checks++;
                if (seg !== 7'h07) begin
                    errors++;
                    $display("FAIL colon_odd_seg: seg=%h want 07", seg);
                end
            end
            repeat (4) @(negedge clk);
        end
        sec1 = 4'd8;
        sync_frame("colon_even");
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (dp !== (i == 1 || i == 3) || com !== ~(6'b000001 << i)) begin
                errors++;
                $display("FAIL colon_even_slot%0d: dp=%b com=%b want %b %b", i, dp, com,
                         (i == 1 || i == 3), ~(6'b000001 << i));
            end
            if (i == 5) begin
                checks++;
                if (seg !== 7'h7F) begin
                    errors++;
                    $display("FAIL colon_even_seg: seg=%h want 7f", seg);
                end
            end
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_invalid_code();
        logic [6:0] exp_seg [6] = '{7'h06, 7'h5B, 7'h00, 7'h66, 7'h6D, 7'h7D};
        set_digits(4'd1, 4'd2, 4'hC, 4'd4, 4'd5, 4'd6);
        sync_frame("invalid");
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (seg !== exp_seg[i] || com !== ~(6'b000001 << i)) begin
                errors++;
                $display("FAIL invalid_slot%0d: seg=%h com=%b want %h %b", i, seg, com,
                         exp_seg[i], ~(6'b000001 << i));
            end
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_slot();
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        sync_frame("rst_mid");
        repeat (14) @(negedge clk);
        checks++;
        if (com !== 6'b110111) begin
            errors++;
            $display("FAIL rst_mid_pre: com=%b want 110111", com);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (seg !== 7'h00 || dp !== 1'b0 || com !== 6'h3F || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_state: seg=%h dp=%b com=%b fd=%b want 00 0 111111 0",
                     seg, dp, com, frame_done);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (frame_done !== (k == 4) || com !== 6'h3F) begin
                errors++;
                $display("FAIL rst_restart_cycle%0d: fd=%b com=%b want fd=%b com=111111",
                         k, frame_done, com, (k == 4));
            end
        end
        @(negedge clk);
        checks++;
        if (seg !== 7'h06 || com !== 6'b111110) begin
            errors++;
            $display("FAIL rst_restart_slot0: seg=%h com=%b want 06 111110", seg, com);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_mid_frame_change();
        test_blanking();
        test_colon();
        test_invalid_code();
        test_reset_mid_slot();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
